// File: rtl/cdb_rr_arbiter_if.sv
// cdb_rr_arbiter_if: FU completion ports and registered CDB lanes of the CDB arbiter.
// CDB_ARB_PERF_EN adds the performance-counter outputs.
interface cdb_rr_arbiter_if #(
    parameter int FU_NUM    = 8,
    parameter int CDB_WIDTH = 2,
    parameter int TAG_W     = 6
);
    localparam int SW = FU_NUM > 1 ? $clog2(FU_NUM) : 1;
    logic                                flush_i;
    logic [FU_NUM-1:0]                   fu_valid_i;
    logic [FU_NUM-1:0][TAG_W-1:0]        fu_tag_i;
    logic [FU_NUM-1:0]                   fu_ready_o;
    logic [CDB_WIDTH-1:0]                cdb_en_o;
    logic [CDB_WIDTH-1:0][TAG_W-1:0]     cdb_tag_o;
    logic [CDB_WIDTH-1:0][SW-1:0]        cdb_src_o;
    logic [$clog2(FU_NUM):0]             pend_cnt_o;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]                         perf_bcast_o;
    logic [31:0]                         perf_stall_o;
    logic [31:0]                         perf_full_o;
    modport master (output flush_i, fu_valid_i, fu_tag_i,
                    input  fu_ready_o, cdb_en_o, cdb_tag_o, cdb_src_o, pend_cnt_o,
                           perf_bcast_o, perf_stall_o, perf_full_o);
    modport slave  (input  flush_i, fu_valid_i, fu_tag_i,
                    output fu_ready_o, cdb_en_o, cdb_tag_o, cdb_src_o, pend_cnt_o,
                           perf_bcast_o, perf_stall_o, perf_full_o);
`else
    modport master (output flush_i, fu_valid_i, fu_tag_i,
                    input  fu_ready_o, cdb_en_o, cdb_tag_o, cdb_src_o, pend_cnt_o);
    modport slave  (input  flush_i, fu_valid_i, fu_tag_i,
                    output fu_ready_o, cdb_en_o, cdb_tag_o, cdb_src_o, pend_cnt_o);
`endif
endinterface

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: per-FU holding slots granted onto CDB_WIDTH registered CDB lanes in rotating priority.
// Define CDB_ARB_PERF_EN to add saturating broadcast/stall/full counters.
module cdb_rr_arbiter #(
    parameter int FU_NUM    = 8,
    parameter int CDB_WIDTH = 2,
    parameter int TAG_W     = 6
) (
    input  logic            clk,
    input  logic            reset,
    cdb_rr_arbiter_if.slave bus
);
    localparam int SW = FU_NUM > 1 ? $clog2(FU_NUM) : 1;
    localparam int CW = $clog2(FU_NUM) + 1;

    logic [FU_NUM-1:0]               pend_v_q, pend_v_d, grant, accept;
    logic [FU_NUM-1:0][TAG_W-1:0]    pend_tag_q, pend_tag_d;
    logic [SW-1:0]                   rr_q, rr_d, idx;
    logic [SW:0]                     s;
    logic [CDB_WIDTH-1:0]            en_q, en_d;
    logic [CDB_WIDTH-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [CDB_WIDTH-1:0][SW-1:0]    src_q, src_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    int                              gcnt;

    // Rotated scan from rr_q; the n-th grant in that order drives lane n.
    always_comb begin
        grant = '0;
        en_d  = '0;
        tag_d = '0;
        src_d = '0;
        rr_d  = rr_q;
        gcnt  = 0;
        s     = '0;
        idx   = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            s   = {1'b0, rr_q} + (SW+1)'(k);
            idx = s >= (SW+1)'(FU_NUM) ? SW'(s - (SW+1)'(FU_NUM)) : SW'(s);
            if (pend_v_q[idx] && gcnt < CDB_WIDTH) begin
                grant[idx] = 1'b1;
                for (int l = 0; l < CDB_WIDTH; l++) begin
                    if (l == gcnt) begin
                        en_d[l]  = 1'b1;
                        tag_d[l] = pend_tag_q[idx];
                        src_d[l] = idx;
                    end
                end
                rr_d = idx == SW'(FU_NUM - 1) ? '0 : idx + 1'b1;
                gcnt++;
            end
        end
        if (bus.flush_i) begin
            en_d  = '0;
            tag_d = '0;
            src_d = '0;
            rr_d  = rr_q;
        end
    end

    assign bus.fu_ready_o = (~pend_v_q | grant) & {FU_NUM{~bus.flush_i}};
    assign accept         = bus.fu_valid_i & bus.fu_ready_o;

    always_comb begin
        pend_v_d   = (pend_v_q & ~grant & {FU_NUM{~bus.flush_i}}) | accept;
        pend_tag_d = pend_tag_q;
        cnt_d      = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            pend_tag_d[i] = accept[i] ? bus.fu_tag_i[i] : pend_tag_q[i];
            cnt_d         = cnt_d + CW'(pend_v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v_q   <= '0;
            pend_tag_q <= '0;
            rr_q       <= '0;
            en_q       <= '0;
            tag_q      <= '0;
            src_q      <= '0;
            cnt_q      <= '0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_tag_q <= pend_tag_d;
            rr_q       <= rr_d;
            en_q       <= en_d;
            tag_q      <= tag_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.cdb_en_o   = en_q;
    assign bus.cdb_tag_o  = tag_q;
    assign bus.cdb_src_o  = src_q;
    assign bus.pend_cnt_o = cnt_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] bc_q, bc_d, st_q, st_d, fl_q, fl_d;
    logic [32:0] bc_sum;

    always_comb begin
        bc_sum = {1'b0, bc_q} + 33'(gcnt);
        bc_d   = bc_sum[32] ? '1 : bc_sum[31:0];
        st_d   = (|(bus.fu_valid_i & ~bus.fu_ready_o) && st_q != '1) ? st_q + 1'b1 : st_q;
        fl_d   = (gcnt == CDB_WIDTH && |(pend_v_q & ~grant) && fl_q != '1) ? fl_q + 1'b1 : fl_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bc_q <= '0;
            st_q <= '0;
            fl_q <= '0;
        end else begin
            bc_q <= bc_d;
            st_q <= st_d;
            fl_q <= fl_d;
        end
    end

    assign bus.perf_bcast_o = bc_q;
    assign bus.perf_stall_o = st_q;
    assign bus.perf_full_o  = fl_q;
`endif
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb_cdb_rr_arbiter: directed test-plan sequences plus random traffic against a slot-level reference model.
module tb_cdb_rr_arbiter;
    localparam int FN  = 4;
    localparam int CWD = 2;
    localparam int TW  = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cdb_rr_arbiter_if #(.FU_NUM(FN), .CDB_WIDTH(CWD), .TAG_W(TW)) bus ();
    cdb_rr_arbiter #(.FU_NUM(FN), .CDB_WIDTH(CWD), .TAG_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    bit                 mv[FN];
    logic [TW-1:0]      mt[FN];
    int                 mptr;
    logic [CWD-1:0]     een;
    logic [CWD*TW-1:0]  etag;
    logic [CWD*2-1:0]   esrc;
    int                 ecnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < FN; i++) begin
            mv[i] = 1'b0;
            mt[i] = '0;
        end
        mptr = 0;
        een  = '0;
        etag = '0;
        esrc = '0;
        ecnt = 0;
    endtask

    // Called at a falling edge: drive, check ready, advance model at the rising edge, check outputs.
    task automatic step(input logic [FN-1:0] v, input logic [FN-1:0][TW-1:0] tg, input logic fl);
        bit            g[FN];
        logic [FN-1:0] rdy;
        logic [TW-1:0] lt[CWD];
        int            ls[CWD];
        int            nl, last, i;
        bus.fu_valid_i = v;
        bus.fu_tag_i   = tg;
        bus.flush_i    = fl;
        nl   = 0;
        last = 0;
        for (int k = 0; k < FN; k++) g[k] = 1'b0;
        for (int l = 0; l < CWD; l++) begin
            lt[l] = '0;
            ls[l] = 0;
        end
        for (int k = 0; k < FN; k++) begin
            i = (mptr + k) % FN;
            if (mv[i] && nl < CWD) begin
                g[i]   = 1'b1;
                lt[nl] = mt[i];
                ls[nl] = i;
                nl++;
                last = i;
            end
        end
        for (int k = 0; k < FN; k++) rdy[k] = (!mv[k] || g[k]) && !fl;
        #1;
        check("fu_ready", 32'(bus.fu_ready_o), 32'(rdy));
        @(posedge clk);
        een  = '0;
        etag = '0;
        esrc = '0;
        if (fl) begin
            for (int k = 0; k < FN; k++) mv[k] = 1'b0;
        end else begin
            for (int l = 0; l < nl; l++) begin
                een[l]            = 1'b1;
                etag[l*TW +: TW]  = lt[l];
                esrc[l*2 +: 2]    = 2'(ls[l]);
            end
            for (int k = 0; k < FN; k++) begin
                if (g[k]) mv[k] = 1'b0;
                if (v[k] && rdy[k]) begin
                    mv[k] = 1'b1;
                    mt[k] = tg[k];
                end
            end
            if (nl > 0) mptr = (last + 1) % FN;
        end
        ecnt = 0;
        for (int k = 0; k < FN; k++) ecnt += int'(mv[k]);
        @(negedge clk);
        check("cdb_en", 32'(bus.cdb_en_o), 32'(een));
        check("cdb_tag", 32'(bus.cdb_tag_o), 32'(etag));
        check("cdb_src", 32'(bus.cdb_src_o), 32'(esrc));
        check("pend_cnt", 32'(bus.pend_cnt_o), 32'(ecnt));
    endtask

    // Asynchronous reset asserted between edges must clear outputs immediately.
    task automatic do_reset();
        bus.fu_valid_i = '0;
        bus.flush_i    = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_en", 32'(bus.cdb_en_o), 32'd0);
        check("rst_cnt", 32'(bus.pend_cnt_o), 32'd0);
        reset_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_step(input int flush_mod);
        logic [FN-1:0][TW-1:0] tg;
        for (int k = 0; k < FN; k++) tg[k] = TW'($urandom);
        step(FN'($urandom), tg, ($urandom % flush_mod) == 0);
    endtask

    localparam logic [FN-1:0][TW-1:0] T0  = '0;
    localparam logic [FN-1:0][TW-1:0] TF  = {6'h13, 6'h12, 6'h11, 6'h10};
    localparam logic [FN-1:0][TW-1:0] TA  = {6'h2d, 6'h2c, 6'h2b, 6'h2a};

    initial begin
        bus.flush_i    = 1'b0;
        bus.fu_valid_i = '0;
        bus.fu_tag_i   = '0;
        reset_model();
        repeat (2) @(negedge clk);
        check("init_en", 32'(bus.cdb_en_o), 32'd0);
        check("init_tag", 32'(bus.cdb_tag_o), 32'd0);
        check("init_src", 32'(bus.cdb_src_o), 32'd0);
        check("init_cnt", 32'(bus.pend_cnt_o), 32'd0);
        reset = 1'b0;
        // single completion
        step(4'b0001, {6'h0, 6'h0, 6'h0, 6'h05}, 1'b0);
        step(4'b0000, T0, 1'b0);
        check("single_tag", 32'(bus.cdb_tag_o[0]), 32'h05);
        step(4'b0000, T0, 1'b0);
        // fairness under full load
        repeat (8) step(4'b1111, TF, 1'b0);
        repeat (3) step(4'b0000, T0, 1'b0);
        // reset mid-operation, then rr pointer must restart at 0
        repeat (5) rand_step(1000);
        step(4'b0101, TA, 1'b0);
        do_reset();
        step(4'b1001, TA, 1'b0);
        step(4'b0000, T0, 1'b0);
        check("rst_ptr_src", 32'(bus.cdb_src_o), 32'({2'd3, 2'd0}));
        step(4'b0000, T0, 1'b0);
        // wrap-around from rr_ptr=3
        do_reset();
        step(4'b0100, TA, 1'b0);
        step(4'b1001, TF, 1'b0);
        step(4'b0000, T0, 1'b0);
        check("wrap_src", 32'(bus.cdb_src_o), 32'({2'd0, 2'd3}));
        step(4'b0011, TA, 1'b0);
        step(4'b0000, T0, 1'b0);
        step(4'b0000, T0, 1'b0);
        // backpressure
        do_reset();
        step(4'b0111, TF, 1'b0);
        step(4'b0001, TA, 1'b0);
        repeat (3) step(4'b0000, T0, 1'b0);
        // flush
        do_reset();
        step(4'b0110, TF, 1'b0);
        step(4'b1000, TA, 1'b1);
        repeat (2) step(4'b0000, T0, 1'b0);
        // random traffic
        for (int r = 0; r < 400; r++) begin
            if ($urandom % 80 == 0) do_reset();
            rand_step(16);
        end
        repeat (4) step(4'b0000, T0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
